// File: rtl/debug_access_unit.sv
// rtl/debug_access_unit.sv - debug command responder: halt/resume, register-file and PC access
module debug_access_unit #(
    parameter int HALT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_addr,
    input  logic [63:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        halt_req,
    input  logic        halted,
    output logic [4:0]  dbg_rf_addr,
    output logic        dbg_rf_we,
    output logic [63:0] dbg_rf_wdata,
    input  logic [63:0] dbg_rf_rdata,
    output logic        dbg_pc_we,
    output logic [31:0] dbg_pc_wdata,
    input  logic [31:0] dbg_pc_rdata
);

    localparam logic [2:0] OP_READ_REG  = 3'd0;
    localparam logic [2:0] OP_WRITE_REG = 3'd1;
    localparam logic [2:0] OP_READ_PC   = 3'd2;
    localparam logic [2:0] OP_WRITE_PC  = 3'd3;
    localparam logic [2:0] OP_HALT      = 3'd4;
    localparam logic [2:0] OP_RESUME    = 3'd5;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACCESS   = 3'd1;
    localparam logic [2:0] S_HALTING  = 3'd2;
    localparam logic [2:0] S_RESUMING = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    localparam logic [15:0] TIMEOUT_LAST = 16'(HALT_TIMEOUT - 1);

    logic [2:0]  state;
    logic [2:0]  op_q;
    logic [15:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= 3'd0;
            wait_cnt     <= 16'd0;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= 64'd0;
            rsp_err      <= 1'b0;
            halt_req     <= 1'b0;
            dbg_rf_addr  <= 5'd0;
            dbg_rf_we    <= 1'b0;
            dbg_rf_wdata <= 64'd0;
            dbg_pc_we    <= 1'b0;
            dbg_pc_wdata <= 32'd0;
        end else begin
            dbg_rf_we <= 1'b0;
            dbg_pc_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        rsp_data  <= 64'd0;
                        rsp_err   <= 1'b0;
                        case (cmd_op)
                            OP_READ_REG, OP_WRITE_REG, OP_READ_PC, OP_WRITE_PC: begin
                                if (!halted) begin
                                    rsp_err   <= 1'b1;
                                    rsp_valid <= 1'b1;
                                    state     <= S_RESP;
                                end else begin
                                    // Strobes are registered here so they are high for exactly the ACCESS cycle
                                    dbg_rf_addr  <= cmd_addr;
                                    dbg_rf_wdata <= cmd_wdata;
                                    dbg_pc_wdata <= cmd_wdata[31:0];
                                    dbg_rf_we    <= (cmd_op == OP_WRITE_REG) && (cmd_addr != 5'd0);
                                    dbg_pc_we    <= (cmd_op == OP_WRITE_PC);
                                    state        <= S_ACCESS;
                                end
                            end
                            OP_HALT: begin
                                halt_req <= 1'b1;
                                if (halted) begin
                                    rsp_valid <= 1'b1;
                                    state     <= S_RESP;
                                end else begin
                                    wait_cnt <= 16'd0;
                                    state    <= S_HALTING;
                                end
                            end
                            OP_RESUME: begin
                                if (halted) begin
                                    halt_req <= 1'b0;
                                    state    <= S_RESUMING;
                                end else begin
                                    rsp_valid <= 1'b1;
                                    state     <= S_RESP;
                                end
                            end
                            default: begin
                                rsp_err   <= 1'b1;
                                rsp_valid <= 1'b1;
                                state     <= S_RESP;
                            end
                        endcase
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    case (op_q)
                        OP_READ_REG: rsp_data <= dbg_rf_rdata;
                        OP_READ_PC:  rsp_data <= {32'd0, dbg_pc_rdata};
                        default:     rsp_data <= 64'd0;
                    endcase
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_HALTING: begin
                    if (halted) begin
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        halt_req  <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_RESUMING: begin
                    if (!halted) begin
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_access_unit.sv
// tb/tb_debug_access_unit.sv - directed self-checking bench for debug_access_unit
module tb_debug_access_unit;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        halt_req;
    logic        halted;
    logic [4:0]  dbg_rf_addr;
    logic        dbg_rf_we;
    logic [63:0] dbg_rf_wdata;
    logic [63:0] dbg_rf_rdata;
    logic        dbg_pc_we;
    logic [31:0] dbg_pc_wdata;
    logic [31:0] dbg_pc_rdata;

    int vectors;
    int miscompares;

    debug_access_unit #(.HALT_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .halt_req(halt_req), .halted(halted),
        .dbg_rf_addr(dbg_rf_addr), .dbg_rf_we(dbg_rf_we), .dbg_rf_wdata(dbg_rf_wdata),
        .dbg_rf_rdata(dbg_rf_rdata),
        .dbg_pc_we(dbg_pc_we), .dbg_pc_wdata(dbg_pc_wdata), .dbg_pc_rdata(dbg_pc_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core-side model: register file and PC updated by the debug strobes
    logic [63:0] regs [32] = '{default: 64'd0};
    logic [31:0] pc_m = 32'h0000_0100;
    int rf_we_cnt = 0;
    int pc_we_cnt = 0;

    always @(posedge clk) begin
        if (dbg_rf_we) begin
            regs[dbg_rf_addr] <= dbg_rf_wdata;
            rf_we_cnt <= rf_we_cnt + 1;
        end
        if (dbg_pc_we) begin
            pc_m <= dbg_pc_wdata;
            pc_we_cnt <= pc_we_cnt + 1;
        end
    end

    assign dbg_rf_rdata = (dbg_rf_addr == 5'd0) ? 64'd0 : regs[dbg_rf_addr];
    assign dbg_pc_rdata = pc_m;

    // Called at a negedge; returns at the negedge following the accept edge
    task automatic issue(input logic [2:0] op, input logic [4:0] addr, input logic [63:0] wd);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_wait: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cmd_ready, rsp_valid, rsp_err, halt_req, dbg_rf_we, dbg_pc_we} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 000000",
                     {cmd_ready, rsp_valid, rsp_err, halt_req, dbg_rf_we, dbg_pc_we});
        end
        vectors++;
        if (rsp_data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_rsp_data: got %h required 0", rsp_data);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b required 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_after_edge: got %b required 1", cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_halt_write_read();
        int base;
        issue(3'd4, 5'd0, 64'd0);
        vectors++;
        if (halt_req !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_req_rise: got %b required 1", halt_req);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_rsp_early: rsp_valid=%b required 0", rsp_valid);
        end
        halted = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL halt_rsp: valid/err=%b required 10", {rsp_valid, rsp_err});
        end
        @(negedge clk);

        base = rf_we_cnt;
        issue(3'd1, 5'd7, 64'd9);
        vectors++;
        if ({dbg_rf_we, dbg_rf_addr, dbg_rf_wdata, rsp_valid} !== {1'b1, 5'd7, 64'd9, 1'b0}) begin
            miscompares++;
            $display("FAIL write_strobe: we=%b addr=%0d data=%h rsp_valid=%b required 1/7/9/0",
                     dbg_rf_we, dbg_rf_addr, dbg_rf_wdata, rsp_valid);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 64'd0}) begin
            miscompares++;
            $display("FAIL write_rsp: valid=%b err=%b data=%h required 1/0/0", rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
        vectors++;
        if (rf_we_cnt - base !== 1) begin
            miscompares++;
            $display("FAIL write_strobe_count: got %0d required 1", rf_we_cnt - base);
        end

        issue(3'd0, 5'd7, 64'd0);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read_rsp_early: rsp_valid=%b required 0", rsp_valid);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 64'd9}) begin
            miscompares++;
            $display("FAIL read_reg: valid=%b err=%b data=%h required 1/0/9", rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_access_without_halt();
        int base;
        issue(3'd5, 5'd0, 64'd0);
        vectors++;
        if (halt_req !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_halt_req: got %b required 0", halt_req);
        end
        halted = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL resume_rsp: valid/err=%b required 10", {rsp_valid, rsp_err});
        end
        @(negedge clk);

        base = pc_we_cnt + rf_we_cnt;
        issue(3'd2, 5'd0, 64'd0);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 64'd0}) begin
            miscompares++;
            $display("FAIL unhalted_read_pc: valid=%b err=%b data=%h required 1/1/0", rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
        vectors++;
        if (pc_we_cnt + rf_we_cnt - base !== 0) begin
            miscompares++;
            $display("FAIL unhalted_strobes: got %0d required 0", pc_we_cnt + rf_we_cnt - base);
        end
    endtask

    task automatic test_write_x0_pc();
        int base;
        issue(3'd4, 5'd0, 64'd0);
        halted = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err, halt_req} !== 3'b101) begin
            miscompares++;
            $display("FAIL rehalt_rsp: valid/err/halt_req=%b required 101", {rsp_valid, rsp_err, halt_req});
        end
        @(negedge clk);

        base = rf_we_cnt;
        issue(3'd1, 5'd0, 64'd5);
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL write_x0_rsp: valid/err=%b required 10", {rsp_valid, rsp_err});
        end
        @(negedge clk);
        vectors++;
        if (rf_we_cnt - base !== 0) begin
            miscompares++;
            $display("FAIL write_x0_strobe: got %0d required 0", rf_we_cnt - base);
        end

        base = pc_we_cnt;
        issue(3'd3, 5'd0, 64'hFFFF_FFFF_0000_0040);
        vectors++;
        if ({dbg_pc_we, dbg_pc_wdata} !== {1'b1, 32'h0000_0040}) begin
            miscompares++;
            $display("FAIL write_pc_strobe: we=%b data=%h required 1/00000040", dbg_pc_we, dbg_pc_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (pc_we_cnt - base !== 1) begin
            miscompares++;
            $display("FAIL write_pc_count: got %0d required 1", pc_we_cnt - base);
        end

        issue(3'd2, 5'd0, 64'd0);
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 64'h40}) begin
            miscompares++;
            $display("FAIL read_pc: valid=%b err=%b data=%h required 1/0/40", rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);

        issue(3'd7, 5'd0, 64'd0);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_data, halt_req} !== {1'b1, 1'b1, 64'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL illegal_op: valid=%b err=%b data=%h halt_req=%b required 1/1/0/1",
                     rsp_valid, rsp_err, rsp_data, halt_req);
        end
        @(negedge clk);
    endtask

    task automatic test_halt_timeout();
        int hcnt;
        issue(3'd5, 5'd0, 64'd0);
        halted = 1'b0;
        @(negedge clk);
        @(negedge clk);

        issue(3'd4, 5'd0, 64'd0);
        hcnt = 0;
        for (int i = 0; i < 40 && halt_req; i++) begin
            hcnt++;
            @(negedge clk);
        end
        vectors++;
        if (hcnt !== 8) begin
            miscompares++;
            $display("FAIL timeout_halt_req_cycles: got %0d required 8", hcnt);
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 64'd0}) begin
            miscompares++;
            $display("FAIL timeout_rsp: valid=%b err=%b data=%h required 1/1/0", rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure_reset();
        int bad;
        rsp_ready = 1'b0;
        issue(3'd6, 5'd0, 64'd0);
        vectors++;
        if ({rsp_valid, rsp_err} !== 2'b11) begin
            miscompares++;
            $display("FAIL bp_rsp: valid/err=%b required 11", {rsp_valid, rsp_err});
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_err, rsp_data, cmd_ready} !== {1'b1, 1'b1, 64'd0, 1'b0}) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release: valid/ready=%b required 01", {rsp_valid, cmd_ready});
        end

        issue(3'd4, 5'd0, 64'd0);
        repeat (2) @(negedge clk);
        vectors++;
        if (halt_req !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_halting: halt_req=%b required 1", halt_req);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({halt_req, rsp_valid, cmd_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL midop_reset_clear: halt_req/valid/ready=%b required 000",
                     {halt_req, rsp_valid, cmd_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({cmd_ready, halt_req} !== 2'b10) begin
            miscompares++;
            $display("FAIL midop_ready_after: ready/halt_req=%b required 10", {cmd_ready, halt_req});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int accepts;
        int good_rsp;
        issue(3'd4, 5'd0, 64'd0);
        halted = 1'b1;
        @(negedge clk);
        @(negedge clk);

        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_addr  = 5'd7;
        cmd_wdata = 64'd0;
        accepts  = 0;
        good_rsp = 0;
        for (int i = 0; i < 12; i++) begin
            if (cmd_ready) accepts++;
            if (rsp_valid && !rsp_err && rsp_data == 64'd9) good_rsp++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        vectors++;
        if (accepts !== 4) begin
            miscompares++;
            $display("FAIL b2b_accepts: got %0d required 4 in 12 cycles", accepts);
        end
        vectors++;
        if (good_rsp !== 4) begin
            miscompares++;
            $display("FAIL b2b_responses: got %0d required 4", good_rsp);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_addr    = 5'd0;
        cmd_wdata   = 64'd0;
        rsp_ready   = 1'b1;
        halted      = 1'b0;
        test_reset();
        test_halt_write_read();
        test_access_without_halt();
        test_write_x0_pc();
        test_halt_timeout();
        test_backpressure_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
